ssp_tx_fifo: RTL

Transmit FIFO of the SSP, 8 entries × 16 bits. It is written from the APB data register path and drained by the serial transmit core in functional mode. In test mode (TESTFIFO=1) it is drained by the test-block read-pointer increment TestTXFInc instead, so software can read the FIFO back through SSPTDR. It sits downstream of the test-register block, consuming TESTFIFO and TestTXFInc, and upstream of the transmit serializer and the TX interrupt/DMA logic.

---
 rtl/ssp_pkg.sv | 7 +
 rtl/ssp_fifo_ram.sv | 34 +++
 rtl/ssp_tx_fifo.sv | 103 ++++++++++
 3 files changed

// File: rtl/ssp_pkg.sv
// Shared SSP constants, used by both the transmit and receive FIFOs.
package ssp_pkg;

  localparam int unsigned SSP_TXFIFO_DEPTH = 8;
  localparam int unsigned SSP_DATA_WIDTH   = 16;

endpackage : ssp_pkg

// File: rtl/ssp_fifo_ram.sv
// Register-array storage for the SSP FIFOs.
// Ports:
//   clk_i      - write clock (rising edge)
//   we_i       - write enable
//   waddr_i    - write address
//   wdata_i    - write data
//   raddr_i    - read address
//   rdata_o    - read data, asynchronous (combinational from raddr_i)
// The array has no reset; the owning FIFO qualifies its output with its own
// pointer and level state.
module ssp_fifo_ram #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 16,
  parameter int unsigned Aw    = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : ssp_fifo_ram

// File: rtl/ssp_tx_fifo.sv
// SSP transmit FIFO: first-word-fall-through, DEPTH x WIDTH.
// Written from the APB data register path, drained by the serializer (TxRd)
// in functional mode or by the test block (TestTXFInc) when TESTFIFO=1.
// Ports:
//   PCLK, PRESETn  - APB clock, asynchronous active-low reset
//   PWDATAIn       - push data
//   SSPDRWr        - push strobe
//   TxRd           - functional pop strobe
//   TESTFIFO       - selects TestTXFInc as the pop source
//   TestTXFInc     - test pop strobe
//   TxFData        - head-of-FIFO data, 0 when empty
//   TxFEmpty, TxFFull, TxFHalfOrLess - status flags from the registered level
//   TxFLevel       - occupancy 0..DEPTH
module ssp_tx_fifo
  import ssp_pkg::*;
#(
  parameter int unsigned DEPTH = SSP_TXFIFO_DEPTH,
  parameter int unsigned WIDTH = SSP_DATA_WIDTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [WIDTH-1:0] PWDATAIn,
  input  logic             SSPDRWr,
  input  logic             TxRd,
  input  logic             TESTFIFO,
  input  logic             TestTXFInc,
  output logic [WIDTH-1:0] TxFData,
  output logic             TxFEmpty,
  output logic             TxFFull,
  output logic             TxFHalfOrLess,
  output logic [AW:0]      TxFLevel
);

  localparam logic [AW:0] LevelFull = (AW+1)'(DEPTH);
  localparam logic [AW:0] LevelHalf = (AW+1)'(DEPTH / 2);

  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             pop;
  logic             push_ok;
  logic             pop_ok;
  logic [WIDTH-1:0] rd_data;

  // The unselected pop source is ignored entirely.
  assign pop = TESTFIFO ? TestTXFInc : TxRd;

  // Acceptance uses only the pre-edge flags, so full+push+pop pops only and
  // empty+push+pop pushes only.
  assign push_ok = SSPDRWr & ~TxFFull;
  assign pop_ok  = pop & ~TxFEmpty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + AW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  ssp_fifo_ram #(
    .Depth (DEPTH),
    .Width (WIDTH),
    .Aw    (AW)
  ) u_ram (
    .clk_i   (PCLK),
    .we_i    (push_ok),
    .waddr_i (wptr_q),
    .wdata_i (PWDATAIn),
    .raddr_i (rptr_q),
    .rdata_o (rd_data)
  );

  assign TxFEmpty      = (level_q == '0);
  assign TxFFull       = (level_q == LevelFull);
  assign TxFHalfOrLess = (level_q <= LevelHalf);
  assign TxFLevel      = level_q;
  // Masking hides stale array contents after reset or drain.
  assign TxFData       = TxFEmpty ? '0 : rd_data;

endmodule : ssp_tx_fifo
